// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, constants and requester ids for the register file writeback path
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;
endpackage

// File: rtl/rf_wb_if.sv
// rtl/rf_wb_if.sv - writeback request, register file write and issue-hazard signals
interface rf_wb_if;
  import rf_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;
  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rs;
  logic [ADDR_W-1:0] iss_rt;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_stall;
  logic [NREGS-1:0]  busy;

  modport master (
    output a_valid, a_reg, a_data, m_valid, m_reg, m_data,
    output iss_valid, iss_rs, iss_rt, iss_rd,
    input  a_ready, m_ready, rf_we, rf_waddr, rf_wdata, iss_stall, busy
  );

  modport slave (
    input  a_valid, a_reg, a_data, m_valid, m_reg, m_data,
    input  iss_valid, iss_rs, iss_rt, iss_rd,
    output a_ready, m_ready, rf_we, rf_waddr, rf_wdata, iss_stall, busy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits and RAW/WAW issue stall
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_rs_i,
  input  logic [ADDR_W-1:0] iss_rt_i,
  input  logic [ADDR_W-1:0] iss_rd_i,
  input  logic              rf_we_i,
  input  logic [ADDR_W-1:0] rf_waddr_i,
  output logic              iss_stall_o,
  output logic [NREGS-1:0]  busy_o
);
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             stall;

  assign stall = iss_valid_i && (busy_q[iss_rs_i] | busy_q[iss_rt_i] | busy_q[iss_rd_i]);

  // Set is applied after clear so a new reservation survives a same-edge retire.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_i) busy_d[rf_waddr_i] = 1'b0;
    if (iss_valid_i && !stall && (iss_rd_i != REG_ZERO)) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign iss_stall_o = stall;
  assign busy_o      = busy_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin ALU/load writeback arbiter with registered register file write stage
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  rf_wb_if.slave  bus
);
  req_id_t           last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              a_grant, m_grant;
  logic              sb_stall;
  logic [NREGS-1:0]  sb_busy;

  // On conflict the requester that did not win last time goes first.
  assign a_grant = bus.a_valid && (!bus.m_valid || (last_grant_q == REQ_MEM));
  assign m_grant = bus.m_valid && (!bus.a_valid || (last_grant_q == REQ_ALU));

  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (a_grant) begin
      last_grant_d = REQ_ALU;
      rf_we_d      = (bus.a_reg != REG_ZERO);
      rf_waddr_d   = bus.a_reg;
      rf_wdata_d   = bus.a_data;
    end else if (m_grant) begin
      last_grant_d = REQ_MEM;
      rf_we_d      = (bus.m_reg != REG_ZERO);
      rf_waddr_d   = bus.m_reg;
      rf_wdata_d   = bus.m_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_MEM;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (bus.iss_valid),
    .iss_rs_i    (bus.iss_rs),
    .iss_rt_i    (bus.iss_rt),
    .iss_rd_i    (bus.iss_rd),
    .rf_we_i     (rf_we_q),
    .rf_waddr_i  (rf_waddr_q),
    .iss_stall_o (sb_stall),
    .busy_o      (sb_busy)
  );

  assign bus.a_ready   = a_grant;
  assign bus.m_ready   = m_grant;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.iss_stall = sb_stall;
  assign bus.busy      = sb_busy;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for the writeback arbiter and busy tracker
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  wr_t               exp_q[$];
  logic [ADDR_W-1:0] wlog[$];
  logic [NREGS-1:0]  mbusy = '0;
  req_id_t           mlast = REQ_MEM;
  logic              mwe = 1'b0;
  logic [ADDR_W-1:0] mwaddr = '0;
  logic [DATA_W-1:0] mwdata = '0;
  logic              a_pend = 1'b0;
  logic              m_pend = 1'b0;
  logic              a_hs, m_hs;

  rf_wb_if bus ();

  rf_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: checks last edge's write and busy, then predicts the coming edge.
  always @(negedge clk) begin
    logic exp_stall, exp_a, exp_m;
    wr_t  e;
    if (rst) begin
      exp_q.delete();
      mbusy  = '0;
      mlast  = REQ_MEM;
      mwe    = 1'b0;
      mwaddr = '0;
      mwdata = '0;
    end else begin
      mwe = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mwe = e.we;
        mwaddr = e.addr;
        mwdata = e.data;
      end
      check("rf_we", 32'(bus.rf_we), 32'(mwe));
      check("rf_waddr", 32'(bus.rf_waddr), 32'(mwaddr));
      check("rf_wdata", bus.rf_wdata, mwdata);
      if (bus.rf_we) wlog.push_back(bus.rf_waddr);
      check("busy", bus.busy, mbusy);
      exp_stall = bus.iss_valid && (mbusy[bus.iss_rs] | mbusy[bus.iss_rt] | mbusy[bus.iss_rd]);
      check("iss_stall", 32'(bus.iss_stall), 32'(exp_stall));
      exp_a = bus.a_valid && (!bus.m_valid || mlast == REQ_MEM);
      exp_m = bus.m_valid && (!bus.a_valid || mlast == REQ_ALU);
      check("a_ready", 32'(bus.a_ready), 32'(exp_a));
      check("m_ready", 32'(bus.m_ready), 32'(exp_m));
      if (exp_a) begin
        exp_q.push_back({bus.a_reg != REG_ZERO, bus.a_reg, bus.a_data});
        mlast = REQ_ALU;
      end else if (exp_m) begin
        exp_q.push_back({bus.m_reg != REG_ZERO, bus.m_reg, bus.m_data});
        mlast = REQ_MEM;
      end
      if (mwe) mbusy[mwaddr] = 1'b0;
      if (bus.iss_valid && !exp_stall && bus.iss_rd != REG_ZERO) mbusy[bus.iss_rd] = 1'b1;
      mbusy[0] = 1'b0;
    end
  end

  // A requester may not withdraw valid before it has been granted.
  always @(posedge clk) begin
    if (rst) begin
      a_pend = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (a_pend && !bus.a_valid) $error("ALU valid dropped before ready");
      if (m_pend && !bus.m_valid) $error("MEM valid dropped before ready");
      a_pend = bus.a_valid && !bus.a_ready;
      m_pend = bus.m_valid && !bus.m_ready;
    end
  end

  task automatic step;
    @(negedge clk);
    a_hs = bus.a_valid && bus.a_ready;
    m_hs = bus.m_valid && bus.m_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic run_reqs(input int na_in, input int nm_in);
    int na = na_in;
    int nm = nm_in;
    bus.a_valid = (na > 0);
    bus.m_valid = (nm > 0);
    for (int c = 0; c < 20 && (na > 0 || nm > 0); c++) begin
      step();
      if (a_hs) begin na--; if (na == 0) bus.a_valid = 1'b0; end
      if (m_hs) begin nm--; if (nm == 0) bus.m_valid = 1'b0; end
    end
    if (na > 0 || nm > 0) check("req_timeout", 32'(na + nm), 32'd0);
  endtask

  initial begin
    bus.a_valid = 0; bus.a_reg = '0; bus.a_data = '0;
    bus.m_valid = 0; bus.m_reg = '0; bus.m_data = '0;
    bus.iss_valid = 0; bus.iss_rs = '0; bus.iss_rt = '0; bus.iss_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_we", 32'(bus.rf_we), 32'd0);
    check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_busy", bus.busy, 32'd0);

    // single ALU write and its latency
    bus.a_valid = 1; bus.a_reg = 5'd5; bus.a_data = 32'hDEADBEEF;
    @(negedge clk); check("single_ready", 32'(bus.a_ready), 32'd1);
    @(posedge clk); #1 bus.a_valid = 0;
    @(negedge clk);
    check("single_we", 32'(bus.rf_we), 32'd1);
    check("single_waddr", 32'(bus.rf_waddr), 32'd5);
    check("single_wdata", bus.rf_wdata, 32'hDEADBEEF);
    @(negedge clk); check("single_we_off", 32'(bus.rf_we), 32'd0);

    // reset while a write is in flight and a register is reserved
    @(posedge clk); #1;
    bus.iss_valid = 1; bus.iss_rd = 5'd4;
    bus.a_valid = 1; bus.a_reg = 5'd3; bus.a_data = 32'h33;
    @(posedge clk); #1;
    bus.a_valid = 0; bus.iss_valid = 0; bus.iss_rd = '0;
    check("mid_we_before", 32'(bus.rf_we), 32'd1);
    check("mid_busy4", 32'(bus.busy[4]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(bus.rf_we), 32'd0);
    check("mid_rst_busy", bus.busy, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // continuous dual requests alternate starting with ALU
    wlog.delete();
    bus.a_reg = 5'd1; bus.a_data = 32'h11;
    bus.m_reg = 5'd2; bus.m_data = 32'h22;
    run_reqs(2, 2);
    repeat (2) @(posedge clk);
    #1;
    check("dual_count", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      check("dual_w0", 32'(wlog[0]), 32'd1);
      check("dual_w1", 32'(wlog[1]), 32'd2);
      check("dual_w2", 32'(wlog[2]), 32'd1);
      check("dual_w3", 32'(wlog[3]), 32'd2);
    end

    // RAW and WAW stalls on r7 until its write retires
    bus.iss_valid = 1; bus.iss_rd = 5'd7;
    @(posedge clk); #1;
    check("busy7_set", 32'(bus.busy[7]), 32'd1);
    bus.iss_rd = '0; bus.iss_rs = 5'd7;
    @(negedge clk); check("raw_stall", 32'(bus.iss_stall), 32'd1);
    @(posedge clk); #1;
    bus.iss_rs = '0; bus.iss_rd = 5'd7;
    @(negedge clk); check("waw_stall", 32'(bus.iss_stall), 32'd1);
    @(posedge clk); #1;
    bus.iss_rs = 5'd7; bus.iss_rd = '0;
    bus.a_reg = 5'd7; bus.a_data = 32'h77;
    run_reqs(1, 0);
    @(negedge clk); check("stall_during_we", 32'(bus.iss_stall), 32'd1);
    @(posedge clk); #1;
    check("stall_released", 32'(bus.iss_stall), 32'd0);
    check("busy7_clear", 32'(bus.busy[7]), 32'd0);
    @(posedge clk); #1;
    bus.iss_valid = 0; bus.iss_rs = '0;

    // r0 writes handshake but never write; rd=0 reserves nothing
    bus.m_valid = 1; bus.m_reg = '0; bus.m_data = 32'h55;
    @(negedge clk); check("r0_ready", 32'(bus.m_ready), 32'd1);
    @(posedge clk); #1 bus.m_valid = 0;
    @(negedge clk); check("r0_we", 32'(bus.rf_we), 32'd0);
    @(posedge clk); #1;
    bus.iss_valid = 1;
    @(negedge clk); check("r0_nostall", 32'(bus.iss_stall), 32'd0);
    @(posedge clk); #1 bus.iss_valid = 0;
    check("r0_busy", bus.busy, 32'd0);

    // retire and reserve r9 on the same edge: reservation wins
    bus.a_reg = 5'd9; bus.a_data = 32'h99;
    run_reqs(1, 0);
    bus.iss_valid = 1; bus.iss_rd = 5'd9;
    @(negedge clk); check("same_edge_nostall", 32'(bus.iss_stall), 32'd0);
    @(posedge clk); #1 bus.iss_valid = 0;
    check("same_edge_busy9", 32'(bus.busy[9]), 32'd1);

    // random traffic against the model
    for (int c = 0; c < 300; c++) begin
      if (!bus.a_valid && $urandom_range(0, 1) == 1) begin
        bus.a_valid = 1; bus.a_reg = 5'($urandom); bus.a_data = $urandom;
      end
      if (!bus.m_valid && $urandom_range(0, 1) == 1) begin
        bus.m_valid = 1; bus.m_reg = 5'($urandom); bus.m_data = $urandom;
      end
      bus.iss_valid = ($urandom_range(0, 3) == 0);
      bus.iss_rs = 5'($urandom); bus.iss_rt = 5'($urandom); bus.iss_rd = 5'($urandom);
      step();
      if (a_hs) bus.a_valid = 0;
      if (m_hs) bus.m_valid = 0;
    end
    bus.iss_valid = 0;
    run_reqs(bus.a_valid ? 1 : 0, bus.m_valid ? 1 : 0);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
